// File: rtl/s_window_stats_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | s_window_stats_pkg                                                         |
// | Shared state encoding, window-size default and SUM width helper.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package s_window_stats_pkg;

  localparam int c_WIN_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Samples are 8 bits, so WIN*255 always fits in 8 + log2(WIN) bits.
  function automatic int sum_width(input int win);
    return 8 + $clog2(win);
  endfunction

endpackage
`default_nettype wire

// File: rtl/s_window_stats_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | s_window_stats_if                                                          |
// | Sample input and window-result handshake bundle for s_window_stats.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface s_window_stats_if
  import s_window_stats_pkg::*;
#(
  parameter int WIN = c_WIN_DEFAULT
);
  localparam int SW = sum_width(WIN);

  logic          in_valid;
  logic [7:0]    S_in;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] SUM;
  logic [7:0]    AVG;
  logic [7:0]    MAX;
  logic [7:0]    MIN;

  modport master (
    output in_valid, S_in, out_ready,
    input  in_ready, out_valid, SUM, AVG, MAX, MIN
  );

  modport slave (
    input  in_valid, S_in, out_ready,
    output in_ready, out_valid, SUM, AVG, MAX, MIN
  );

endinterface
`default_nettype wire

// File: rtl/s_window_stats.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | s_window_stats                                                             |
// | Collects WIN unsigned samples and reports their sum, mean, max and min.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module s_window_stats
  import s_window_stats_pkg::*;
#(
  parameter int WIN = c_WIN_DEFAULT
)(
  input  logic            clk,
  input  logic            clear,
  s_window_stats_if.slave bus
);

  localparam int LOG2W = $clog2(WIN);
  localparam int SW    = sum_width(WIN);
  localparam int CW    = LOG2W + 1;
  localparam logic [CW-1:0] c_LAST_CNT = CW'(WIN - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [SW-1:0] r_sum;
  logic [7:0]    r_max;
  logic [7:0]    r_min;
  logic [SW-1:0] r_sum_out;
  logic [7:0]    r_avg_out;
  logic [7:0]    r_max_out;
  logic [7:0]    r_min_out;

  logic          w_in_ready;
  logic          w_out_valid;
  logic          w_accept;
  logic          w_first;
  logic          w_last;
  logic [SW-1:0] w_sum_nxt;
  logic [7:0]    w_max_nxt;
  logic [7:0]    w_min_nxt;

  assign w_accept = bus.in_valid && w_in_ready;
  // Any accept outside ACCUM opens a new window, including the DONE hand-over.
  assign w_first  = w_accept && (r_state != ACCUM);
  assign w_last   = w_accept && (r_state == ACCUM) && (r_cnt == c_LAST_CNT);

  always_ff @(posedge clk) begin
    if (!clear) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b1;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) w_state_nxt = ACCUM;
      end
      ACCUM: begin
        if (bus.in_valid && (r_cnt == c_LAST_CNT)) w_state_nxt = DONE;
      end
      DONE: begin
        w_out_valid = 1'b1;
        w_in_ready  = bus.out_ready;
        if (bus.out_ready) w_state_nxt = bus.in_valid ? ACCUM : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_sum_nxt = r_sum + SW'(bus.S_in);
    w_max_nxt = r_max;
    w_min_nxt = r_min;
    if (w_first) begin
      w_sum_nxt = SW'(bus.S_in);
      w_max_nxt = bus.S_in;
      w_min_nxt = bus.S_in;
    end else begin
      if (bus.S_in > r_max) w_max_nxt = bus.S_in;
      if (bus.S_in < r_min) w_min_nxt = bus.S_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      r_cnt     <= '0;
      r_sum     <= '0;
      r_max     <= '0;
      r_min     <= '0;
      r_sum_out <= '0;
      r_avg_out <= '0;
      r_max_out <= '0;
      r_min_out <= '0;
    end else begin
      if (w_accept) begin
        r_sum <= w_sum_nxt;
        r_max <= w_max_nxt;
        r_min <= w_min_nxt;
        r_cnt <= w_first ? CW'(1) : r_cnt + CW'(1);
      end
      if (w_last) begin
        r_sum_out <= w_sum_nxt;
        // Upper SW-LOG2W bits of the sum are exactly the truncated mean.
        r_avg_out <= w_sum_nxt[SW-1:LOG2W];
        r_max_out <= w_max_nxt;
        r_min_out <= w_min_nxt;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.SUM       = r_sum_out;
  assign bus.AVG       = r_avg_out;
  assign bus.MAX       = r_max_out;
  assign bus.MIN       = r_min_out;

endmodule
`default_nettype wire

// File: tb/tb_s_window_stats.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_s_window_stats                                                          |
// | Self-checking bench for s_window_stats with a queue-based window model.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_s_window_stats;
  import s_window_stats_pkg::*;

  localparam int WIN = c_WIN_DEFAULT;
  localparam int SW  = sum_width(WIN);

  logic clk = 1'b0;
  logic clear;
  int   checks   = 0;
  int   failures = 0;

  int win_q[$];
  int exp_sum, exp_avg, exp_max, exp_min;

  s_window_stats_if #(.WIN(WIN)) bus ();

  s_window_stats #(.WIN(WIN)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic void model_result();
    exp_sum = 0;
    exp_max = 0;
    exp_min = 255;
    foreach (win_q[i]) begin
      exp_sum += win_q[i];
      if (win_q[i] > exp_max) exp_max = win_q[i];
      if (win_q[i] < exp_min) exp_min = win_q[i];
    end
    exp_avg = exp_sum / WIN;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int v);
    bus.in_valid = 1'b1;
    bus.S_in     = 8'(v);
    cyc();
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b1;
    bus.S_in      = 8'd123;
    bus.out_ready = 1'b1;
    clear = 1'b0;
    cyc();
    cyc();
    checks++;
    if ({bus.out_valid, bus.SUM, bus.AVG, bus.MAX, bus.MIN} !== '0) begin
      failures++;
      $display("FAIL reset_outputs actual v=%0d sum=%0d avg=%0d max=%0d min=%0d required all 0",
               bus.out_valid, bus.SUM, bus.AVG, bus.MAX, bus.MIN);
    end
    clear = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready actual=%0b required=1", bus.in_ready);
    end
    cyc();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle_valid actual=%0b required=0", bus.out_valid);
    end
  endtask

  task automatic test_basic();
    win_q.delete();
    for (int v = 1; v <= WIN; v++) begin
      feed(v);
      win_q.push_back(v);
    end
    model_result();
    checks++;
    if ({bus.out_valid, bus.SUM, bus.AVG, bus.MAX, bus.MIN} !==
        {1'b1, SW'(exp_sum), 8'(exp_avg), 8'(exp_max), 8'(exp_min)}) begin
      failures++;
      $display("FAIL basic_result actual v=%0d sum=%0d avg=%0d max=%0d min=%0d required v=1 sum=%0d avg=%0d max=%0d min=%0d",
               bus.out_valid, bus.SUM, bus.AVG, bus.MAX, bus.MIN, exp_sum, exp_avg, exp_max, exp_min);
    end
    bus.in_valid = 1'b0;
    cyc();
    checks++;
    if ({bus.out_valid, bus.SUM} !== {1'b0, SW'(exp_sum)}) begin
      failures++;
      $display("FAIL basic_hold actual v=%0d sum=%0d required v=0 sum=%0d", bus.out_valid, bus.SUM, exp_sum);
    end
  endtask

  task automatic test_extremes();
    int pats[2] = '{255, 0};
    foreach (pats[p]) begin
      win_q.delete();
      repeat (WIN) begin
        feed(pats[p]);
        win_q.push_back(pats[p]);
      end
      model_result();
      checks++;
      if ({bus.out_valid, bus.SUM, bus.AVG, bus.MAX, bus.MIN} !==
          {1'b1, SW'(exp_sum), 8'(exp_avg), 8'(exp_max), 8'(exp_min)}) begin
        failures++;
        $display("FAIL extreme_result actual v=%0d sum=%0d avg=%0d max=%0d min=%0d required v=1 sum=%0d avg=%0d max=%0d min=%0d",
                 bus.out_valid, bus.SUM, bus.AVG, bus.MAX, bus.MIN, exp_sum, exp_avg, exp_max, exp_min);
      end
      bus.in_valid = 1'b0;
      cyc();
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    win_q.delete();
    repeat (WIN) begin
      int v;
      v = int'($urandom_range(0, 255));
      feed(v);
      win_q.push_back(v);
    end
    model_result();
    bus.in_valid = 1'b1;
    bus.S_in     = 8'd9;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.SUM, bus.AVG, bus.MAX, bus.MIN} !==
          {1'b0, 1'b1, SW'(exp_sum), 8'(exp_avg), 8'(exp_max), 8'(exp_min)}) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d actual rdy=%0d v=%0d sum=%0d avg=%0d max=%0d min=%0d required rdy=0 v=1 sum=%0d avg=%0d max=%0d min=%0d",
                 k, bus.in_ready, bus.out_valid, bus.SUM, bus.AVG, bus.MAX, bus.MIN, exp_sum, exp_avg, exp_max, exp_min);
      end
      cyc();
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release_ready actual=%0b required=1", bus.in_ready);
    end
    cyc();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release_valid actual=%0b required=0", bus.out_valid);
    end
    win_q.delete();
    win_q.push_back(9);
    repeat (WIN - 1) begin
      int v;
      v = int'($urandom_range(0, 255));
      feed(v);
      win_q.push_back(v);
    end
    model_result();
    checks++;
    if ({bus.out_valid, bus.SUM, bus.AVG, bus.MAX, bus.MIN} !==
        {1'b1, SW'(exp_sum), 8'(exp_avg), 8'(exp_max), 8'(exp_min)}) begin
      failures++;
      $display("FAIL bp_next_window actual v=%0d sum=%0d avg=%0d max=%0d min=%0d required v=1 sum=%0d avg=%0d max=%0d min=%0d",
               bus.out_valid, bus.SUM, bus.AVG, bus.MAX, bus.MIN, exp_sum, exp_avg, exp_max, exp_min);
    end
    bus.in_valid = 1'b0;
    cyc();
  endtask

  task automatic test_back_to_back();
    int seq[$];
    int pulses[$];
    for (int v = 1; v <= WIN; v++) seq.push_back(v);
    for (int v = WIN; v >= 1; v--) seq.push_back(v);
    bus.out_ready = 1'b1;
    win_q.delete();
    foreach (seq[i]) begin
      feed(seq[i]);
      win_q.push_back(seq[i]);
      if (bus.out_valid === 1'b1) pulses.push_back(i);
      checks++;
      if (bus.out_valid !== ((i % WIN) == WIN - 1)) begin
        failures++;
        $display("FAIL b2b_valid step=%0d actual=%0b required=%0b", i, bus.out_valid, ((i % WIN) == WIN - 1));
      end
      if (win_q.size() == WIN) begin
        model_result();
        win_q.delete();
        checks++;
        if ({bus.SUM, bus.AVG, bus.MAX, bus.MIN} !==
            {SW'(exp_sum), 8'(exp_avg), 8'(exp_max), 8'(exp_min)}) begin
          failures++;
          $display("FAIL b2b_result step=%0d actual sum=%0d avg=%0d max=%0d min=%0d required sum=%0d avg=%0d max=%0d min=%0d",
                   i, bus.SUM, bus.AVG, bus.MAX, bus.MIN, exp_sum, exp_avg, exp_max, exp_min);
        end
      end
    end
    checks++;
    if (pulses.size() != 2 || (pulses[1] - pulses[0]) != WIN) begin
      failures++;
      $display("FAIL b2b_spacing actual pulses=%0d required 2 pulses %0d cycles apart", pulses.size(), WIN);
    end
    bus.in_valid = 1'b0;
    cyc();
  endtask

  task automatic test_clear_mid_window();
    bus.out_ready = 1'b1;
    repeat (5) feed(int'($urandom_range(1, 255)));
    bus.S_in = 8'd77;
    clear = 1'b0;
    cyc();
    cyc();
    checks++;
    if ({bus.out_valid, bus.SUM, bus.AVG, bus.MAX, bus.MIN} !== '0) begin
      failures++;
      $display("FAIL clear_outputs actual v=%0d sum=%0d avg=%0d max=%0d min=%0d required all 0",
               bus.out_valid, bus.SUM, bus.AVG, bus.MAX, bus.MIN);
    end
    clear = 1'b1;
    win_q.delete();
    for (int v = 1; v <= WIN; v++) begin
      feed(v);
      win_q.push_back(v);
    end
    model_result();
    checks++;
    if ({bus.out_valid, bus.SUM, bus.AVG, bus.MAX, bus.MIN} !==
        {1'b1, SW'(exp_sum), 8'(exp_avg), 8'(exp_max), 8'(exp_min)}) begin
      failures++;
      $display("FAIL clear_refill actual v=%0d sum=%0d avg=%0d max=%0d min=%0d required v=1 sum=%0d avg=%0d max=%0d min=%0d",
               bus.out_valid, bus.SUM, bus.AVG, bus.MAX, bus.MIN, exp_sum, exp_avg, exp_max, exp_min);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    cyc();
    clear = 1'b0;
    cyc();
    clear = 1'b1;
    bus.out_ready = 1'b1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL clear_in_done actual=%0b required=0", bus.out_valid);
    end
  endtask

  task automatic test_gaps();
    int vals[8] = '{3, 7, 200, 1, 50, 9, 9, 0};
    bus.out_ready = 1'b1;
    win_q.delete();
    foreach (vals[i]) begin
      feed(vals[i]);
      win_q.push_back(vals[i]);
      if (i == 7) begin
        model_result();
        checks++;
        if ({bus.out_valid, bus.SUM, bus.AVG, bus.MAX, bus.MIN} !==
            {1'b1, SW'(exp_sum), 8'(exp_avg), 8'(exp_max), 8'(exp_min)}) begin
          failures++;
          $display("FAIL gaps_result actual v=%0d sum=%0d avg=%0d max=%0d min=%0d required v=1 sum=%0d avg=%0d max=%0d min=%0d",
                   bus.out_valid, bus.SUM, bus.AVG, bus.MAX, bus.MIN, exp_sum, exp_avg, exp_max, exp_min);
        end
      end
      bus.in_valid = 1'b0;
      bus.S_in     = 8'($urandom_range(0, 255));
      cyc();
      checks++;
      if (bus.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL gaps_valid step=%0d actual=%0b required=0", i, bus.out_valid);
      end
    end
  endtask

  task automatic test_random();
    bit   pending = 1'b0;
    logic exp_rdy;
    win_q.delete();
    repeat (300) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.S_in      = 8'($urandom_range(0, 255));
      bus.out_ready = ($urandom_range(0, 2) != 0);
      #1;
      exp_rdy = !pending || bus.out_ready;
      checks++;
      if (bus.in_ready !== exp_rdy) begin
        failures++;
        $display("FAIL rand_in_ready actual=%0b required=%0b", bus.in_ready, exp_rdy);
      end
      if (pending && bus.out_ready) pending = 1'b0;
      if (bus.in_valid && exp_rdy) begin
        win_q.push_back(int'(bus.S_in));
        if (win_q.size() == WIN) begin
          model_result();
          win_q.delete();
          pending = 1'b1;
        end
      end
      cyc();
      checks++;
      if (bus.out_valid !== pending) begin
        failures++;
        $display("FAIL rand_out_valid actual=%0b required=%0b", bus.out_valid, pending);
      end
      if (pending) begin
        checks++;
        if ({bus.SUM, bus.AVG, bus.MAX, bus.MIN} !==
            {SW'(exp_sum), 8'(exp_avg), 8'(exp_max), 8'(exp_min)}) begin
          failures++;
          $display("FAIL rand_result actual sum=%0d avg=%0d max=%0d min=%0d required sum=%0d avg=%0d max=%0d min=%0d",
                   bus.SUM, bus.AVG, bus.MAX, bus.MIN, exp_sum, exp_avg, exp_max, exp_min);
        end
      end
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.S_in      = 8'd0;
    bus.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_extremes();
    test_backpressure();
    test_back_to_back();
    test_clear_mid_window();
    test_gaps();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/s_window_stats.md
S_WINDOW_STATS -- requirements
Module: s_window_stats

Interface
REQ-001 Parameter WIN, default 8, samples per statistics window; legal values 2, 4, 8, 16 only.
REQ-002 Derived constant SW = 8 + log2(WIN), the SUM width (11 at default).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 clear  input  1  reset, synchronous, active-low: clear=0 at a rising clk edge resets the block.
REQ-005 in_valid  input  1  S_in holds a valid sample this cycle.
REQ-006 S_in  input  8  unsigned sample, the registered S output of the upstream arithmetic stage.
REQ-007 in_ready  output  1  block accepts a sample this cycle.
REQ-008 out_valid  output  1  window result is valid and held.
REQ-009 out_ready  input  1  consumer takes the result this cycle.
REQ-010 SUM  output  SW  sum of the window's samples.
REQ-011 AVG  output  8  SUM >> log2(WIN), truncated.
REQ-012 MAX  output  8  largest sample in the window.
REQ-013 MIN  output  8  smallest sample in the window.

Function
REQ-014 A sample is accepted only when in_valid=1 and in_ready=1 at a rising edge.
REQ-015 The FSM has three states: IDLE, ACCUM and DONE.
REQ-016 In IDLE: in_ready=1 and out_valid=0.
- On an accepted sample: sum=S_in, max=min=S_in, cnt=1, go to ACCUM.
REQ-017 In ACCUM: in_ready=1.
- Each accepted sample: sum+=S_in, max/min updated with unsigned compare, cnt+=1.
- No accept: all state held. in_valid gaps of any length are legal.
REQ-018 When the accepted sample is the WIN-th of the window, on that same edge:
- Load SUM, AVG, MAX and MIN from the final values.
- Go to DONE.
- out_valid=1 from the next cycle, so latency is 1 cycle after the last accepted sample.
REQ-019 In DONE: out_valid=1, SUM/AVG/MAX/MIN stable, in_ready=out_ready.
REQ-020 DONE with out_ready=0: hold state and outputs, accept no sample (backpressure).
REQ-021 DONE with out_ready=1 and in_valid=0: result taken, go to IDLE, out_valid=0 the next cycle.
REQ-022 DONE with out_ready=1 and in_valid=1 in the same cycle:
- Result is taken and the sample is accepted as the first of the next window (cnt=1).
- Go to ACCUM, out_valid=0 the next cycle.
- No sample is lost and no bubble is inserted.
REQ-023 SUM cannot overflow: WIN*255 fits in SW bits; there is no saturation logic.
REQ-024 SUM/AVG/MAX/MIN change only on the REQ-018 edge; they keep their last value after out_valid deasserts.
REQ-025 The sample counter wraps only through REQ-018/REQ-022; it never exceeds WIN.

Reset
REQ-026 When clear=0 at a rising edge, the following are forced, regardless of state or inputs:
- state=IDLE, cnt=0, internal sum/max/min=0.
- SUM=0, AVG=0, MAX=0, MIN=0, out_valid=0.
REQ-027 in_ready=1 in the first cycle after reset deasserts.
REQ-028 Reset mid-window discards the partial window; reset in DONE discards the unconsumed result.
REQ-029 Any sample presented while clear=0 is not accepted.

Structure
REQ-030 A shared package holds the state enum (IDLE, ACCUM, DONE) and the WIN default constant, so the upstream and downstream benches use the same values.
REQ-031 The block is a single module with no sub-module; the min/max compare is inline.

Verification (WIN=8)
REQ-032 Feed 1..8 on consecutive cycles with out_ready=1 -> one cycle after sample 8: out_valid=1, SUM=36, AVG=4, MAX=8, MIN=1.
REQ-033 Feed eight samples of 255 -> SUM=2040, AVG=255, MAX=MIN=255; feed eight samples of 0 -> all outputs 0.
REQ-034 Complete a window with out_ready=0 for 5 cycles while in_valid=1 with sample 9 -> in_ready=0 and outputs stable for those 5 cycles; sample 9 is accepted on the out_ready=1 cycle and becomes the first sample of the next window.
REQ-035 Back-to-back windows 1..8 then 8..1 with continuous in_valid=1 and out_ready=1 -> both results are correct (36/4/8/1 each), with a 1-cycle out_valid pulse 8 cycles apart.
REQ-036 clear=0 after 5 samples, then the full sequence 1..8 -> result is exactly SUM=36; no residue from the aborted window.
REQ-037 in_valid toggling 1,0,1,0 across the window of 3,7,200,1,50,9,9,0 -> SUM=279, AVG=34, MAX=200, MIN=0; out_valid=1 one cycle after the 8th accepted sample.
